spatz_issue_ctrl: RTL

In-order issue controller between `spatz_decoder` and the Spatz execution resources: the vector functional unit (VFU), the vector load/store unit (VLSU) and the vector CSR file (`spatz_vcsr`). It holds one decoded request and tracks pending vector-register writes in a scoreboard. It stalls on RAW/WAW hazards and dispatches to the target unit over valid/ready handshakes. Configuration ops are serialised behind all in-flight vector work.

---
 rtl/spatz_pkg.sv | 40 ++++
 rtl/spatz_scoreboard.sv | 67 ++++++
 rtl/spatz_issue_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spatz_pkg.sv
// Shared types for the Spatz issue path: execution-unit selector, register index
// and the decoded request carried from the decoder to the units.
package spatz_pkg;

   localparam int unsigned NrVregs = 32;

   typedef logic [$clog2(NrVregs)-1:0] vreg_idx_t;

   typedef enum logic [1:0] {
      CON = 2'd0,
      VFU = 2'd1,
      LSU = 2'd2
   } ex_unit_e;

   typedef enum logic [2:0] {
      OP_VSETVL = 3'd0,
      OP_VADD   = 3'd1,
      OP_VMUL   = 3'd2,
      OP_VLE    = 3'd3,
      OP_VSE    = 3'd4
   } op_e;

   typedef struct packed {
      op_e         op;
      ex_unit_e    ex_unit;
      vreg_idx_t   vd;
      vreg_idx_t   vs1;
      vreg_idx_t   vs2;
      logic        use_vd;
      logic        use_vs1;
      logic        use_vs2;
      logic [7:0]  vtype;
      logic [15:0] avl;
   } spatz_req_t;

   function automatic logic writes_vreg(ex_unit_e unit);
      return (unit == VFU) || (unit == LSU);
   endfunction

endpackage

// File: rtl/spatz_scoreboard.sv
// Pending-write bitvector with one set port, two clear ports and a 3-index hazard lookup.
// SPATZ_SB_FWD_EN masks same-cycle clears out of the hazard and empty checks.
module spatz_scoreboard
   import spatz_pkg::*;
#(
   parameter int unsigned NrVregs      = spatz_pkg::NrVregs,
   parameter int unsigned VregIdxWidth = $clog2(NrVregs)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         set_en_i,
   input  logic [VregIdxWidth-1:0]      set_idx_i,
   input  logic                         clr_a_en_i,
   input  logic [VregIdxWidth-1:0]      clr_a_idx_i,
   input  logic                         clr_b_en_i,
   input  logic [VregIdxWidth-1:0]      clr_b_idx_i,
   input  logic [2:0]                   rd_en_i,
   input  logic [2:0][VregIdxWidth-1:0] rd_idx_i,
   output logic                         hazard_o,
   output logic                         empty_o,
   output logic [NrVregs-1:0]           sb_o
);

   logic [NrVregs-1:0] sb_q, sb_d;
   logic [NrVregs-1:0] set_mask, clr_mask, sb_view;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en_i)   set_mask[set_idx_i]   = 1'b1;
      if (clr_a_en_i) clr_mask[clr_a_idx_i] = 1'b1;
      if (clr_b_en_i) clr_mask[clr_b_idx_i] = 1'b1;
      // a new write to the same register is still outstanding, so set dominates
      sb_d = (sb_q & ~clr_mask) | set_mask;
   end

`ifdef SPATZ_SB_FWD_EN
   assign sb_view = sb_q & ~clr_mask;
`else
   assign sb_view = sb_q;
`endif

   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (rd_en_i[i] && sb_view[rd_idx_i[i]]) hazard_o = 1'b1;
      end
   end

   assign empty_o = ~|sb_view;
   assign sb_o    = sb_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sb_q <= '0;
      else         sb_q <= sb_d;
   end

`ifndef SYNTHESIS
   a_vfu_rsp_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
      clr_a_en_i |-> sb_q[clr_a_idx_i])
      else $error("spatz_scoreboard: VFU response for non-pending register");
   a_vlsu_rsp_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
      clr_b_en_i |-> sb_q[clr_b_idx_i])
      else $error("spatz_scoreboard: VLSU response for non-pending register");
`endif

endmodule

// File: rtl/spatz_issue_ctrl.sv
// In-order issue controller: holds one decoded request, stalls on RAW/WAW hazards
// and serialises CSR writes behind in-flight work. Build option: SPATZ_SB_FWD_EN.
//
//  state | meaning
//  IDLE  | no request held, ready to accept
//  ISSUE | request held, waiting for hazards/unit handshake
module spatz_issue_ctrl
   import spatz_pkg::*;
#(
   parameter int unsigned NrVregs      = spatz_pkg::NrVregs,
   parameter int unsigned VregIdxWidth = $clog2(NrVregs)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  spatz_req_t              req_i,
   output logic                    vfu_req_valid_o,
   input  logic                    vfu_req_ready_i,
   output logic                    vlsu_req_valid_o,
   input  logic                    vlsu_req_ready_i,
   output spatz_req_t              issue_req_o,
   input  logic                    vfu_rsp_valid_i,
   input  logic [VregIdxWidth-1:0] vfu_rsp_vd_i,
   input  logic                    vlsu_rsp_valid_i,
   input  logic [VregIdxWidth-1:0] vlsu_rsp_vd_i,
   output logic                    vcsr_we_o,
   output logic                    busy_o
);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e     state_q, state_d;
   spatz_req_t req_q;
   logic       load, handshake, hazard, sb_empty;
   logic [NrVregs-1:0]           sb;
   logic [2:0][VregIdxWidth-1:0] rd_idx;

   assign rd_idx = {VregIdxWidth'(req_q.vd), VregIdxWidth'(req_q.vs2), VregIdxWidth'(req_q.vs1)};

   spatz_scoreboard #(
      .NrVregs      (NrVregs),
      .VregIdxWidth (VregIdxWidth)
   ) u_sb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .set_en_i    (handshake && writes_vreg(req_q.ex_unit) && req_q.use_vd),
      .set_idx_i   (VregIdxWidth'(req_q.vd)),
      .clr_a_en_i  (vfu_rsp_valid_i),
      .clr_a_idx_i (vfu_rsp_vd_i),
      .clr_b_en_i  (vlsu_rsp_valid_i),
      .clr_b_idx_i (vlsu_rsp_vd_i),
      .rd_en_i     ({req_q.use_vd, req_q.use_vs2, req_q.use_vs1}),
      .rd_idx_i    (rd_idx),
      .hazard_o    (hazard),
      .empty_o     (sb_empty),
      .sb_o        (sb)
   );

   always_comb begin
      state_d          = state_q;
      req_ready_o      = 1'b0;
      vfu_req_valid_o  = 1'b0;
      vlsu_req_valid_o = 1'b0;
      vcsr_we_o        = 1'b0;
      handshake        = 1'b0;
      load             = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            unique case (req_q.ex_unit)
               VFU: begin
                  vfu_req_valid_o = !hazard;
                  handshake       = !hazard && vfu_req_ready_i;
               end
               LSU: begin
                  vlsu_req_valid_o = !hazard;
                  handshake        = !hazard && vlsu_req_ready_i;
               end
               CON: begin
                  vcsr_we_o = sb_empty && !hazard;
                  handshake = sb_empty && !hazard;
               end
               // illegal unit: retire without dispatch
               default: handshake = 1'b1;
            endcase
            if (handshake) begin
               req_ready_o = 1'b1;
               load        = req_valid_i;
               state_d     = req_valid_i ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) req_q <= req_i;
      end
   end

   assign issue_req_o = req_q;
   assign busy_o      = (state_q == ISSUE) || (|sb);

`ifndef SYNTHESIS
   a_legal_unit : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ISSUE) |-> (req_q.ex_unit inside {CON, VFU, LSU}))
      else $error("spatz_issue_ctrl: illegal ex_unit dropped");
`endif

endmodule
